// File: rtl/sr_cbrt_seq_pkg.sv
// Shared ALU opcodes and cube-root FSM encodings for the func-instruction path.
package sr_cbrt_seq_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;

  typedef enum logic [1:0] {
    CBRT_IDLE  = 2'd0,
    CBRT_SHIFT = 2'd1,
    CBRT_CMP   = 2'd2,
    CBRT_SUB   = 2'd3
  } cbrt_state_e;

  localparam logic [2:0] CBRT_S_INIT = 3'd6;
  localparam logic [2:0] CBRT_S_STEP = 3'd3;

  // 3y(y+1)+1 for y <= 6 peaks at 127
  localparam int TERM_W = 7;

endpackage

// File: rtl/sr_cbrt_seq_term.sv
// Combinational cube-root trial term: 3y(y+1)+1, valid for y in 0..6.
module sr_cbrt_term
  import sr_cbrt_seq_pkg::*;
(
  input  logic [2:0]        y,
  output logic [TERM_W-1:0] term
);

  logic [7:0] yy;
  logic [7:0] prod;

  always_comb begin
    yy   = {5'd0, y};
    prod = yy * (yy + 8'd1);
    term = TERM_W'(prod * 8'd3 + 8'd1);
  end

endmodule

// File: rtl/sr_cbrt_seq.sv
// Iterative restoring cube root; all shift/compare/subtract work is borrowed
// from the shared CPU ALU through the alu_a/alu_b/alu_op/alu_res port.
module sr_cbrt_seq
  import sr_cbrt_seq_pkg::*;
#(
  parameter int XW = 8,
  parameter int YW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [XW-1:0] x_bi,
  output logic [15:0]   alu_a,
  output logic [15:0]   alu_b,
  output logic [2:0]    alu_op,
  input  logic [15:0]   alu_res,
  output logic          busy_o,
  output logic          ready_o,
  output logic [YW-1:0] y_bo
);

  cbrt_state_e   state;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [2:0]    s_r;
  logic [15:0]   b_r;
  logic          done_r;

  logic [YW-1:0]     y2;
  logic [TERM_W-1:0] term;
  logic              iterDone;

  assign y2 = y_r << 1;

  sr_cbrt_term uTerm (
    .y    (y2),
    .term (term)
  );

  // ALU drive depends only on registered state so the borrow port stays glitch-free per cycle
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = '0;
    alu_b  = '0;
    unique case (state)
      CBRT_SHIFT: begin
        alu_a  = 16'(term);
        alu_b  = 16'(s_r);
        alu_op = ALU_SLL;
      end
      CBRT_CMP: begin
        alu_a  = 16'(x_r);
        alu_b  = b_r;
        alu_op = ALU_SLTU;
      end
      CBRT_SUB: begin
        alu_a  = 16'(x_r);
        alu_b  = b_r;
        alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

  // an iteration ends either on a failed compare or after the subtract
  assign iterDone = (state == CBRT_SUB) || ((state == CBRT_CMP) && alu_res[0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= CBRT_IDLE;
      x_r    <= '0;
      y_r    <= '0;
      s_r    <= '0;
      b_r    <= '0;
      done_r <= 1'b0;
    end else begin
      unique case (state)
        CBRT_IDLE: begin
          if (start_i) begin
            x_r    <= x_bi;
            y_r    <= '0;
            s_r    <= CBRT_S_INIT;
            done_r <= 1'b0;
            state  <= CBRT_SHIFT;
          end
        end
        CBRT_SHIFT: begin
          b_r   <= alu_res;
          y_r   <= y2;
          state <= CBRT_CMP;
        end
        CBRT_CMP: begin
          if (!alu_res[0]) state <= CBRT_SUB;
        end
        CBRT_SUB: begin
          x_r <= alu_res[XW-1:0];
          y_r <= y_r + YW'(1);
        end
        default: state <= CBRT_IDLE;
      endcase

      if (iterDone) begin
        if (s_r == 3'd0) begin
          done_r <= 1'b1;
          state  <= CBRT_IDLE;
        end else begin
          s_r   <= s_r - CBRT_S_STEP;
          state <= CBRT_SHIFT;
        end
      end
    end
  end

  assign busy_o  = (state != CBRT_IDLE);
  assign ready_o = done_r & (state == CBRT_IDLE);
  assign y_bo    = y_r;

endmodule

// File: tb/tb_sr_cbrt_seq.sv
// Self-checking bench for sr_cbrt_seq: behavioural ALU plus a plain-arithmetic cube-root reference.
module tb_sr_cbrt_seq;
  import sr_cbrt_seq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  x_bi;
  logic [15:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_op;
  logic        busy_o, ready_o;
  logic [2:0]  y_bo;

  int nCmp = 0;
  int nBad = 0;
  logic [2:0] opQ[$];

  sr_cbrt_seq #(.XW(8), .YW(3)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .x_bi    (x_bi),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_res (alu_res),
    .busy_o  (busy_o),
    .ready_o (ready_o),
    .y_bo    (y_bo)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLL:  alu_res = alu_a << alu_b;
      ALU_SLTU: alu_res = {15'd0, (alu_a < alu_b)};
      default:  alu_res = 16'hdead;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cbrtRef(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // one subtract per set bit of the root, on top of 3 x (SHIFT+CMP) and the start cycle
  function automatic int latRef(input int x);
    int r = cbrtRef(x);
    return 7 + ((r >> 2) & 1) + ((r >> 1) & 1) + (r & 1);
  endfunction

  // launch one operation; lat is the cycle index (start edge = T, SHIFT = T+1) where ready shows
  task automatic doOp(input logic [7:0] x, output int y, output int lat, output bit busyOk);
    int k;
    lat = -1;
    busyOk = 1'b1;
    opQ.delete();
    @(negedge clk_i);
    start_i = 1'b1;
    x_bi    = x;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    k = 0;
    while (k < 20) begin
      if (busy_o) opQ.push_back(alu_op);
      else busyOk = 1'b0;
      @(posedge clk_i);
      #1;
      k++;
      if (ready_o) begin
        lat = k + 1;
        break;
      end
    end
    y = int'(y_bo);
    if (lat < 0) chk("timeout", 32'(k), 32'd0);
  endtask

  initial begin
    int y, lat, k;
    bit bOk;
    logic [2:0] exp125[8];
    logic [7:0] xr;
    exp125 = '{ALU_SLL, ALU_SLTU, ALU_SUB, ALU_SLL, ALU_SLTU, ALU_SLL, ALU_SLTU, ALU_SUB};

    rst_i = 1'b1; start_i = 1'b0; x_bi = 8'd0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_y", y_bo, 0);
    chk("rst_op", alu_op, ALU_ADD);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // directed x = 125: result, latency, busy, opcode trace, hold
    doOp(8'd125, y, lat, bOk);
    chk("x125_y", y, 5);
    chk("x125_lat", lat, 9);
    chk("x125_busy", bOk, 1);
    chk("x125_nops", opQ.size(), 8);
    for (int i = 0; i < 8 && i < opQ.size(); i++) chk($sformatf("x125_op%0d", i), opQ[i], exp125[i]);
    repeat (3) @(posedge clk_i);
    #1;
    chk("x125_hold_ready", ready_o, 1);
    chk("x125_hold_y", y_bo, 5);

    doOp(8'd255, y, lat, bOk); chk("x255_y", y, 6); chk("x255_lat", lat, 9);
    doOp(8'd0, y, lat, bOk);   chk("x0_y", y, 0);   chk("x0_lat", lat, 7);
    doOp(8'd7, y, lat, bOk);   chk("x7_y", y, 1);
    doOp(8'd8, y, lat, bOk);   chk("x8_y", y, 2);

    for (int x = 0; x < 256; x++) begin
      doOp(8'(x), y, lat, bOk);
      chk($sformatf("sweep_y%0d", x), y, cbrtRef(x));
      chk($sformatf("sweep_lat%0d", x), lat, latRef(x));
    end

    for (int n = 0; n < 24; n++) begin
      xr = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      doOp(xr, y, lat, bOk);
      chk($sformatf("rand_y%0d", xr), y, cbrtRef(int'(xr)));
      chk($sformatf("rand_lat%0d", xr), lat, latRef(int'(xr)));
      chk("rand_busy", bOk, 1);
    end

    // start held high: single computation, restart taken on the ready cycle
    @(negedge clk_i);
    start_i = 1'b1;
    x_bi = 8'd27;
    @(posedge clk_i);
    #1;
    bOk = 1'b1;
    k = 0;
    while (k < 20) begin
      if (!busy_o) bOk = 1'b0;
      @(posedge clk_i);
      #1;
      k++;
      if (ready_o) break;
    end
    chk("held_lat", k + 1, 9);
    chk("held_busy", bOk, 1);
    chk("held_y", y_bo, 3);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    chk("held_ready_drop", ready_o, 0);
    chk("held_restart_busy", busy_o, 1);
    k = 0;
    while (!ready_o && k < 20) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    chk("held_second_ready", ready_o, 1);
    chk("held_second_y", y_bo, 3);

    // reset in the CMP of the second iteration
    @(negedge clk_i);
    start_i = 1'b1;
    x_bi = 8'd200;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    chk("mid_op_cmp", alu_op, ALU_SLTU);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_ready", ready_o, 0);
    chk("mid_rst_y", y_bo, 0);
    chk("mid_rst_op", alu_op, ALU_ADD);
    doOp(8'd64, y, lat, bOk);
    chk("after_rst_y", y, 4);
    chk("after_rst_lat", lat, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
